wave_stats: RTL and testbench

Per-channel waveform measurement stage sitting between the ADC channel outputs (CH0–CH7, or the test sine) and the `Measure` / `sevenseg` path. On each accepted sample it tracks running minimum and maximum over a fixed sample window, and latches min, max and peak-to-peak at window end. It detects rising crossings of the previous window's mid-level with hysteresis, and reports the signal period in samples. All outputs are registered and held stable between updates so the display logic can read them at any time.

---
 rtl/wave_stats_pkg.sv | 15 +
 rtl/wave_stats_schmitt_edge.sv | 51 +++++
 rtl/wave_stats.sv | 149 ++++++++++++++
 tb/tb_wave_stats.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_stats_pkg.sv
// Shared types and defaults for the per-channel waveform statistics stage.
// Also supplies the period width reused by the Measure path.
package wave_stats_pkg;

    localparam int DATA_W_DEF   = 12;
    localparam int PERIOD_W_DEF = 20;

    typedef logic [DATA_W_DEF-1:0] sample_t;

    typedef enum logic {
        XS_LOW  = 1'b0,
        XS_HIGH = 1'b1
    } xs_t;

endpackage

// File: rtl/wave_stats_schmitt_edge.sv
// Hysteresis crossing detector: pulses rise on the sample that
// lifts the signal from below lo_th to at or above hi_th.
module schmitt_edge
    import wave_stats_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] hi_th,
    input  logic [DATA_W-1:0] lo_th,
    input  logic              enable,
    output logic              rise
);

    xs_t state;
    xs_t state_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= XS_LOW;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rise      = 1'b0;
        if (!enable) begin
            state_nxt = XS_LOW;
        end else if (sample_en) begin
            unique case (state)
                XS_LOW: begin
                    if (sample_data >= hi_th) begin
                        state_nxt = XS_HIGH;
                        rise      = 1'b1;
                    end
                end
                XS_HIGH: begin
                    if (sample_data < lo_th) begin
                        state_nxt = XS_LOW;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/wave_stats.sv
// Windowed min/max/peak-to-peak and crossing-period measurement
// for one channel; all results registered and held between updates.
module wave_stats
    import wave_stats_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WINDOW   = 4096,
    parameter int HYST     = 16,
    parameter int PERIOD_W = PERIOD_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                sample_en,
    input  logic [DATA_W-1:0]   sample_data,
    input  logic                hold,
    output logic [DATA_W-1:0]   vmin_out,
    output logic [DATA_W-1:0]   vmax_out,
    output logic [DATA_W-1:0]   vpp_out,
    output logic                stats_valid,
    output logic [PERIOD_W-1:0] period_out,
    output logic                period_valid
);

    localparam int WCNT_W = $clog2(WINDOW);
    localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(WINDOW - 1);
    localparam logic [WCNT_W-1:0] WONE  = WCNT_W'(1);
    localparam logic [DATA_W:0] HYST_X  = (DATA_W + 1)'(HYST);
    localparam logic [DATA_W:0] HYST2_X = (DATA_W + 1)'(2 * HYST);
    localparam logic [DATA_W:0] DMAX_X  = {1'b0, {DATA_W{1'b1}}};
    localparam logic [PERIOD_W-1:0] PMAX = '1;
    localparam logic [PERIOD_W-1:0] PONE = PERIOD_W'(1);

    logic                accept;
    logic                win_end;
    logic                enable;
    logic                rise;
    logic                win_rise;
    logic                quiet;
    logic                have_edge;
    logic [DATA_W-1:0]   cur_min;
    logic [DATA_W-1:0]   cur_max;
    logic [DATA_W-1:0]   nxt_min;
    logic [DATA_W-1:0]   nxt_max;
    logic [DATA_W-1:0]   mid;
    logic [DATA_W-1:0]   hi_th;
    logic [DATA_W-1:0]   lo_th;
    logic [DATA_W:0]     mid_x;
    logic [DATA_W:0]     mid_sum;
    logic [DATA_W:0]     hi_sum;
    logic [WCNT_W-1:0]   wcnt;
    logic [PERIOD_W-1:0] pcnt;

    assign accept  = sample_en & ~hold;
    assign win_end = accept && (wcnt == WLAST);

    assign nxt_min = (sample_data < cur_min) ? sample_data : cur_min;
    assign nxt_max = (sample_data > cur_max) ? sample_data : cur_max;
    assign mid_sum = {1'b0, nxt_min} + {1'b0, nxt_max};

    assign mid_x  = {1'b0, mid};
    assign hi_sum = mid_x + HYST_X;
    assign hi_th  = (hi_sum > DMAX_X) ? '1 : DATA_W'(hi_sum);
    assign lo_th  = (mid_x < HYST_X) ? '0 : DATA_W'(mid_x - HYST_X);

    // Small signals would chatter around mid; only measure real swings.
    assign enable = stats_valid && ({1'b0, vpp_out} >= HYST2_X);

    schmitt_edge #(
        .DATA_W(DATA_W)
    ) u_edge (
        .clock      (clock),
        .reset      (reset),
        .sample_en  (accept),
        .sample_data(sample_data),
        .hi_th      (hi_th),
        .lo_th      (lo_th),
        .enable     (enable),
        .rise       (rise)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vmin_out    <= '0;
            vmax_out    <= '0;
            vpp_out     <= '0;
            stats_valid <= 1'b0;
            mid         <= {1'b1, {(DATA_W - 1){1'b0}}};
            cur_min     <= '1;
            cur_max     <= '0;
            wcnt        <= '0;
        end else if (accept) begin
            if (win_end) begin
                vmin_out    <= nxt_min;
                vmax_out    <= nxt_max;
                vpp_out     <= nxt_max - nxt_min;
                stats_valid <= 1'b1;
                mid         <= DATA_W'(mid_sum >> 1);
                cur_min     <= '1;
                cur_max     <= '0;
                wcnt        <= '0;
            end else begin
                cur_min <= nxt_min;
                cur_max <= nxt_max;
                wcnt    <= wcnt + WONE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period_out   <= '0;
            period_valid <= 1'b0;
            pcnt         <= '0;
            have_edge    <= 1'b0;
            win_rise     <= 1'b0;
            quiet        <= 1'b0;
        end else if (accept) begin
            if (rise) begin
                if (have_edge && pcnt != PMAX) begin
                    period_out   <= pcnt;
                    period_valid <= 1'b1;
                end
                pcnt      <= PONE;
                have_edge <= 1'b1;
            end else if (pcnt != PMAX) begin
                pcnt <= pcnt + PONE;
                if (pcnt == PMAX - PONE) begin
                    period_valid <= 1'b0;
                    have_edge    <= 1'b0;
                end
            end
            // quiet marks that the previous window had no rising event
            if (win_end) begin
                win_rise <= 1'b0;
                if (win_rise || rise) begin
                    quiet <= 1'b0;
                end else begin
                    quiet <= 1'b1;
                    if (quiet) begin
                        period_valid <= 1'b0;
                    end
                end
            end else if (rise) begin
                win_rise <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wave_stats.sv
// Self-checking bench for wave_stats: directed scenarios plus randomized
// waveforms, compared every cycle against a behavioural window/period model.
module tb_wave_stats;
    import wave_stats_pkg::*;

    localparam int DW   = 12;
    localparam int WIN  = 64;
    localparam int HY   = 16;
    localparam int PW   = 20;
    localparam int DMAX = (1 << DW) - 1;
    localparam int PMAX = (1 << PW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          sample_en = 1'b0;
    logic          hold = 1'b0;
    logic [DW-1:0] sample_data = '0;
    logic [DW-1:0] vmin_out, vmax_out, vpp_out;
    logic          stats_valid, period_valid;
    logic [PW-1:0] period_out;

    wave_stats #(
        .DATA_W  (DW),
        .WINDOW  (WIN),
        .HYST    (HY),
        .PERIOD_W(PW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sample_en   (sample_en),
        .sample_data (sample_data),
        .hold        (hold),
        .vmin_out    (vmin_out),
        .vmax_out    (vmax_out),
        .vpp_out     (vpp_out),
        .stats_valid (stats_valid),
        .period_out  (period_out),
        .period_valid(period_valid)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: sample buffer per window, rise times by index.
    int m_vmin = 0, m_vmax = 0, m_vpp = 0, m_sv = 0;
    int m_per = 0, m_pv = 0, m_mid = 1 << (DW - 1);
    int m_high = 0, m_have = 0, m_last = 0, m_idx = 0;
    int m_wrise = 0, m_quiet = 0, m_rises = 0;
    int wbuf[$];
    int dut_rises = 0;

    task automatic model_reset();
        m_vmin = 0; m_vmax = 0; m_vpp = 0; m_sv = 0;
        m_per = 0; m_pv = 0; m_mid = 1 << (DW - 1);
        m_high = 0; m_have = 0; m_last = 0; m_idx = 0;
        m_wrise = 0; m_quiet = 0; m_rises = 0;
        wbuf.delete();
    endtask

    task automatic model_step(input int s);
        int hi, lo, mn, mx;
        bit en, rs;
        en = (m_sv != 0) && (m_vpp >= 2 * HY);
        hi = (m_mid + HY > DMAX) ? DMAX : m_mid + HY;
        lo = (m_mid < HY) ? 0 : m_mid - HY;
        rs = en && (m_high == 0) && (s >= hi);
        if (!en) m_high = 0;
        else if (rs) m_high = 1;
        else if (m_high != 0 && s < lo) m_high = 0;
        m_idx++;
        if (rs) begin
            m_rises++;
            if (m_have != 0 && (m_idx - m_last) < PMAX) begin
                m_per = m_idx - m_last;
                m_pv = 1;
            end
            m_have = 1;
            m_last = m_idx;
            m_wrise = 1;
        end else if (m_have != 0 && (m_idx - m_last + 1) >= PMAX) begin
            m_pv = 0;
            m_have = 0;
        end
        wbuf.push_back(s);
        if (wbuf.size() == WIN) begin
            mn = DMAX;
            mx = 0;
            foreach (wbuf[k]) begin
                if (wbuf[k] < mn) mn = wbuf[k];
                if (wbuf[k] > mx) mx = wbuf[k];
            end
            m_vmin = mn; m_vmax = mx; m_vpp = mx - mn;
            m_sv = 1;
            m_mid = (mn + mx) / 2;
            if (m_wrise != 0) m_quiet = 0;
            else begin
                m_quiet++;
                if (m_quiet >= 2) m_pv = 0;
            end
            m_wrise = 0;
            wbuf.delete();
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) model_reset();
        else if (sample_en && !hold) model_step(int'(sample_data));
    end

    always @(posedge clock or posedge reset) begin
        if (reset) dut_rises = 0;
        else if (dut.rise) dut_rises++;
    end

    always @(negedge clock) begin
        check("vmin", int'(vmin_out), m_vmin);
        check("vmax", int'(vmax_out), m_vmax);
        check("vpp", int'(vpp_out), m_vpp);
        check("stats_valid", int'(stats_valid), m_sv);
        check("period", int'(period_out), m_per);
        check("period_valid", int'(period_valid), m_pv);
        check("rise_count", dut_rises, m_rises);
    end

    task automatic send(input int v);
        @(negedge clock);
        sample_en = 1'b1;
        hold = 1'b0;
        sample_data = DW'(v);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            sample_en = 1'b0;
            hold = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        sample_en = 1'b0;
        #1 reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    int r0;
    int v;

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset_vmin", int'(vmin_out), 0);
        check("reset_pv", int'(period_valid), 0);

        // Ramp 100..163
        for (int i = 0; i < 63; i++) send(100 + i);
        idle(1);
        check("ramp_sv_early", int'(stats_valid), 0);
        send(163);
        idle(1);
        check("ramp_vmin", int'(vmin_out), 100);
        check("ramp_vmax", int'(vmax_out), 163);
        check("ramp_vpp", int'(vpp_out), 63);
        check("ramp_sv", int'(stats_valid), 1);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 30; i++) send($urandom_range(0, DMAX));
        @(negedge clock);
        sample_en = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("areset_vmin", int'(vmin_out), 0);
        check("areset_vmax", int'(vmax_out), 0);
        check("areset_vpp", int'(vpp_out), 0);
        check("areset_sv", int'(stats_valid), 0);
        @(negedge clock);
        reset = 1'b0;

        // Window giving mid=2048, then hysteresis noise
        for (int i = 0; i < 32; i++) send(2000);
        for (int i = 0; i < 31; i++) send(2096);
        idle(1);
        check("win1_sv_early", int'(stats_valid), 0);
        send(2096);
        idle(1);
        check("win1_sv", int'(stats_valid), 1);
        check("win1_vpp", int'(vpp_out), 96);
        r0 = dut_rises;
        for (int i = 0; i < 40; i++) send((i % 2 != 0) ? 2060 : 2040);
        idle(1);
        check("hyst_none", dut_rises - r0, 0);
        send(2070);
        idle(1);
        check("hyst_one", dut_rises - r0, 1);

        // Small signal
        pulse_reset();
        for (int i = 0; i < 3 * WIN; i++) send((i % 2 != 0) ? 2060 : 2040);
        idle(1);
        check("small_vpp", int'(vpp_out), 20);
        check("small_rises", dut_rises, 0);
        check("small_pv", int'(period_valid), 0);

        // Square wave, period 20
        pulse_reset();
        for (int i = 0; i < 90; i++) send((i % 20 < 10) ? 0 : DMAX);
        idle(1);
        check("sq_pv_before", int'(period_valid), 0);
        send(DMAX);
        idle(1);
        check("sq_pv_second", int'(period_valid), 1);
        check("sq_period_second", int'(period_out), 20);
        for (int i = 91; i < 200; i++) send((i % 20 < 10) ? 0 : DMAX);
        idle(1);
        check("sq_period", int'(period_out), 20);
        check("sq_pv", int'(period_valid), 1);

        // Hold with strobes present
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            hold = 1'b1;
            sample_en = 1'b1;
            sample_data = DW'($urandom_range(0, DMAX));
        end
        idle(1);
        check("hold_vmin", int'(vmin_out), 0);
        check("hold_vmax", int'(vmax_out), DMAX);
        check("hold_period", int'(period_out), 20);

        // Stopped signal: two empty windows drop period_valid
        for (int i = 0; i < 56; i++) send(2000);
        idle(1);
        check("stop_pv_one", int'(period_valid), 1);
        for (int i = 0; i < 63; i++) send(2000);
        idle(1);
        check("stop_pv_almost", int'(period_valid), 1);
        send(2000);
        idle(1);
        check("stop_pv", int'(period_valid), 0);
        check("stop_period", int'(period_out), 20);

        // Randomized waveforms with gaps and holds
        pulse_reset();
        for (int seg = 0; seg < 10; seg++) begin
            int p, amp, nz, sq, t, half, d;
            p = $urandom_range(8, 50);
            amp = $urandom_range(0, 2047);
            nz = $urandom_range(0, 20);
            sq = $urandom_range(0, 1);
            half = p / 2;
            t = 0;
            for (int c = 0; c < 400; c++) begin
                @(negedge clock);
                hold = ($urandom_range(0, 99) < 4);
                sample_en = ($urandom_range(0, 9) < 8);
                d = t % p;
                if (sq != 0) v = (d < half) ? 2048 - amp : 2048 + amp;
                else begin
                    d = (d < half) ? d : p - d;
                    v = 2048 - amp + (d * 2 * amp) / half;
                end
                v = v + $urandom_range(0, 2 * nz) - nz;
                if (v < 0) v = 0;
                if (v > DMAX) v = DMAX;
                sample_data = DW'(v);
                if (sample_en && !hold) t++;
            end
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
